// File: rtl/stage3.sv
// Memory/writeback stage: captures an executed instruction, runs the data-memory handshake
// and drives the register-file write port. Define STAGE3_MISALIGN_TRAP_EN to trap misaligned accesses.
module stage3 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instruction_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_data_in,
    input  logic [31:0] immediate_in,
    input  logic [31:0] pc_plus_4_in,
    output logic        stall,
    output logic        dmem_req,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data
`ifdef STAGE3_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpAluI  = 7'b0010011;
    localparam logic [6:0] OpAluR  = 7'b0110011;
    localparam logic [6:0] OpAuipc = 7'b0010111;

`ifdef STAGE3_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StMemReq, StMemWait, StWb} state_e;

    state_e      state_q;
    logic [31:0] instr_q, alu_q, wdata_q, imm_q, pc4_q, load_q;
    logic        mis_q;

    logic        capture, in_is_mem, in_mis;
    logic [6:0]  in_op, op_q;
    logic [2:0]  f3_q;
    logic        is_load, is_store, wb_en;
    logic [31:0] shifted, load_ext;

    assign in_op     = instruction_in[6:0];
    assign in_is_mem = (in_op == OpLoad) || (in_op == OpStore);
    assign capture   = in_valid && !stall;

    // Size lives in funct3[1:0] for both loads and stores
    always_comb begin
        in_mis = 1'b0;
        if (TrapEn && in_is_mem) begin
            unique case (instruction_in[13:12])
                2'b01:   in_mis = alu_result[0];
                2'b10:   in_mis = (alu_result[1:0] != 2'b00);
                default: in_mis = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            instr_q <= '0;
            alu_q   <= '0;
            wdata_q <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            load_q  <= '0;
            mis_q   <= 1'b0;
        end else if (capture) begin
            instr_q <= instruction_in;
            alu_q   <= alu_result;
            wdata_q <= mem_data_in;
            imm_q   <= immediate_in;
            pc4_q   <= pc_plus_4_in;
            mis_q   <= in_mis;
            state_q <= (in_is_mem && !in_mis) ? StMemReq : StWb;
        end else begin
            unique case (state_q)
                StMemReq: begin
                    if (dmem_ready) begin
                        if (is_store) begin
                            state_q <= StWb;
                        end else if (dmem_rvalid) begin
                            load_q  <= dmem_rdata;
                            state_q <= StWb;
                        end else begin
                            state_q <= StMemWait;
                        end
                    end
                end
                StMemWait: begin
                    if (dmem_rvalid) begin
                        load_q  <= dmem_rdata;
                        state_q <= StWb;
                    end
                end
                StWb:    state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign op_q     = instr_q[6:0];
    assign f3_q     = instr_q[14:12];
    assign is_load  = (op_q == OpLoad);
    assign is_store = (op_q == OpStore);
    assign wb_en    = is_load || (op_q == OpLui) || (op_q == OpJal) || (op_q == OpJalr) ||
                      (op_q == OpAluI) || (op_q == OpAluR) || (op_q == OpAuipc);

    assign stall     = (state_q == StMemReq) || (state_q == StMemWait);
    assign dmem_req  = (state_q == StMemReq);
    assign dmem_addr = {alu_q[31:2], 2'b00};

    always_comb begin
        dmem_we = 4'b0000;
        unique case (f3_q[1:0])
            2'b00:   dmem_wdata = {4{wdata_q[7:0]}};
            2'b01:   dmem_wdata = {2{wdata_q[15:0]}};
            default: dmem_wdata = wdata_q;
        endcase
        if (dmem_req && is_store) begin
            unique case (f3_q[1:0])
                2'b00:   dmem_we = 4'b0001 << alu_q[1:0];
                2'b01:   dmem_we = alu_q[1] ? 4'b1100 : 4'b0011;
                2'b10:   dmem_we = 4'b1111;
                default: dmem_we = 4'b0000;
            endcase
        end
    end

    assign shifted = load_q >> {alu_q[1:0], 3'b000};

    always_comb begin
        unique case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = load_q;
        endcase
        if (is_load) begin
            rd_data = load_ext;
        end else if (op_q == OpLui) begin
            rd_data = imm_q;
        end else if ((op_q == OpJal) || (op_q == OpJalr)) begin
            rd_data = pc4_q;
        end else begin
            rd_data = alu_q;
        end
    end

    assign rd_addr = instr_q[11:7];
    assign rd_we   = (state_q == StWb) && wb_en && (rd_addr != 5'd0) && !mis_q;

`ifdef STAGE3_MISALIGN_TRAP_EN
    assign misaligned = (state_q == StWb) && mis_q;
`endif

endmodule

// File: tb/tb_stage3.sv
// Scoreboard bench for stage3: expected writebacks queued at issue, popped on rd_we.
module tb_stage3;

    logic        clk, rst, in_valid;
    logic [31:0] instruction_in, alu_result, mem_data_in, immediate_in, pc_plus_4_in;
    logic        stall, dmem_req, dmem_ready, dmem_rvalid, rd_we;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, rd_data;
    logic [4:0]  rd_addr;
`ifdef STAGE3_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    stage3 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction_in(instruction_in),
        .alu_result(alu_result), .mem_data_in(mem_data_in), .immediate_in(immediate_in),
        .pc_plus_4_in(pc_plus_4_in), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .rd_we(rd_we), .rd_addr(rd_addr),
        .rd_data(rd_data)
`ifdef STAGE3_MISALIGN_TRAP_EN
        , .misaligned(misaligned)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [36:0] sb[$];
    logic [36:0] mon_e;
    int ready_dly = 0;
    int rvalid_dly = 0;
    logic [31:0] mem_rdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [2:0] f3);
        return {17'd0, f3, rd, op};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] imm, input logic [31:0] pc4);
        @(negedge clk);
        instruction_in = ins; alu_result = alu; mem_data_in = wd;
        immediate_in = imm; pc_plus_4_in = pc4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (stall) check(tag, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Memory responder: ready after ready_dly request cycles, load data rvalid_dly cycles later
    initial begin
        int wait_cnt, rv_cnt;
        wait_cnt = 0;
        rv_cnt = -1;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_ready = 1'b0;
            dmem_rvalid = 1'b0;
            if (dmem_req) begin
                if (wait_cnt >= ready_dly) begin
                    dmem_ready = 1'b1;
                    wait_cnt = 0;
                    if (dmem_we == 4'b0000) begin
                        if (rvalid_dly == 0) begin
                            dmem_rvalid = 1'b1;
                            dmem_rdata = mem_rdata;
                        end else begin
                            rv_cnt = rvalid_dly;
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata = mem_rdata;
                    rv_cnt = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rd_we) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", {31'd0, rd_we}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_addr", {27'd0, rd_addr}, {27'd0, mon_e[36:32]});
                check("wb_data", rd_data, mon_e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        instruction_in = '0; alu_result = '0; mem_data_in = '0;
        immediate_in = '0; pc_plus_4_in = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {28'd0, stall, dmem_req, rd_we, |dmem_we}, 32'd0);
        check("rst_data", rd_data | dmem_addr | dmem_wdata | {27'd0, rd_addr}, 32'd0);
        rst = 1'b0;

        // ADD x5: writeback the cycle after capture
        sb.push_back({5'd5, 32'h7});
        issue(mk(7'b0110011, 5'd5, 3'd0), 32'h7, '0, '0, '0);
        check("add_we", {31'd0, rd_we}, 32'd1);
        check("add_stall", {31'd0, stall}, 32'd0);

        // SB at 0x1003 with ready held off 3 cycles
        ready_dly = 3;
        issue(mk(7'b0100011, 5'd0, 3'd0), 32'h1003, 32'hAB, '0, '0);
        check("sb_we", {28'd0, dmem_we}, 32'h8);
        check("sb_addr", dmem_addr, 32'h1000);
        check("sb_wdata", dmem_wdata, 32'hABABABAB);
        for (int i = 0; i < 3; i++) begin
            check("sb_stall", {30'd0, stall, rd_we}, 32'h2);
            @(negedge clk);
        end
        wait_idle("sb_timeout");
        ready_dly = 0;

        issue(mk(7'b0100011, 5'd0, 3'd1), 32'h1002, 32'h5555_1234, '0, '0);
        check("sh_we", {28'd0, dmem_we}, 32'hC);
        check("sh_wdata", dmem_wdata, 32'h12341234);
        wait_idle("sh_timeout");
        issue(mk(7'b0100011, 5'd0, 3'd2), 32'h1000, 32'hCAFEF00D, '0, '0);
        check("sw_we", {28'd0, dmem_we}, 32'hF);
        check("sw_wdata", dmem_wdata, 32'hCAFEF00D);
        wait_idle("sw_timeout");

        // Loads with rvalid 2 cycles after ready
        rvalid_dly = 2;
        mem_rdata = 32'h0080_0000;
        sb.push_back({5'd1, 32'hFFFF_FF80});
        issue(mk(7'b0000011, 5'd1, 3'd0), 32'h2002, '0, '0, '0);
        check("lb_we", {28'd0, dmem_we}, 32'h0);
        check("lb_addr", dmem_addr, 32'h2000);
        wait_idle("lb_timeout");
        sb.push_back({5'd1, 32'h0000_0080});
        issue(mk(7'b0000011, 5'd1, 3'd4), 32'h2002, '0, '0, '0);
        wait_idle("lbu_timeout");
        mem_rdata = 32'h8001_0000;
        sb.push_back({5'd2, 32'hFFFF_8001});
        issue(mk(7'b0000011, 5'd2, 3'd1), 32'h2002, '0, '0, '0);
        wait_idle("lh_timeout");
        mem_rdata = 32'h0000_F00F;
        sb.push_back({5'd2, 32'h0000_F00F});
        issue(mk(7'b0000011, 5'd2, 3'd5), 32'h2000, '0, '0, '0);
        wait_idle("lhu_timeout");

        // LW with ready and rvalid together: writeback two cycles after capture
        rvalid_dly = 0;
        mem_rdata = 32'hDEADBEEF;
        sb.push_back({5'd7, 32'hDEADBEEF});
        issue(mk(7'b0000011, 5'd7, 3'd2), 32'h2004, '0, '0, '0);
        check("lw_req", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        check("lw_fast_we", {31'd0, rd_we}, 32'd1);

        // JAL x0 suppressed, JALR x4 links, LUI x3, branch never writes
        issue(mk(7'b1101111, 5'd0, 3'd0), 32'h40, '0, '0, 32'h104);
        check("jal_x0_we", {31'd0, rd_we}, 32'd0);
        sb.push_back({5'd4, 32'h104});
        issue(mk(7'b1100111, 5'd4, 3'd0), 32'h40, '0, '0, 32'h104);
        sb.push_back({5'd3, 32'h12345000});
        issue(mk(7'b0110111, 5'd3, 3'd0), 32'h99, '0, 32'h12345000, '0);
        check("lui_data", rd_data, 32'h12345000);
        issue(mk(7'b1100011, 5'd7, 3'd0), 32'h1, '0, '0, '0);
        check("br_we", {31'd0, rd_we}, 32'd0);

        // Back-to-back ALU ops, second captured during WB
        sb.push_back({5'd6, 32'h11});
        sb.push_back({5'd8, 32'h22});
        @(negedge clk);
        instruction_in = mk(7'b0010011, 5'd6, 3'd0); alu_result = 32'h11; in_valid = 1'b1;
        @(negedge clk);
        instruction_in = mk(7'b0010111, 5'd8, 3'd0); alu_result = 32'h22;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_we", {31'd0, rd_we}, 32'd1);
        @(negedge clk);

        // Reset during MEM_WAIT; late rvalid must not write back
        rvalid_dly = 4;
        issue(mk(7'b0000011, 5'd9, 3'd2), 32'h4000, '0, '0, '0);
        @(negedge clk);
        check("rw_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rw_ctrl", {28'd0, stall, dmem_req, rd_we, |dmem_we}, 32'd0);
        check("rw_data", rd_data | dmem_addr | dmem_wdata | {27'd0, rd_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rw_late_we", {30'd0, rd_we, stall}, 32'd0);
        end
        rvalid_dly = 0;

`ifdef STAGE3_MISALIGN_TRAP_EN
        issue(mk(7'b0000011, 5'd10, 3'd2), 32'h3002, '0, '0, '0);
        check("mis_pulse", {29'd0, misaligned, dmem_req, rd_we}, 32'h4);
        @(negedge clk);
        check("mis_clear", {30'd0, misaligned, dmem_req}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage3.md
STAGE3 -- requirements
Module: stage3

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, execute stage presents a valid instruction.
REQ-004 SHALL have port instruction_in, input, 32, instruction forwarded by execute.
REQ-005 SHALL have port alu_result, input, 32, ALU output or effective address.
REQ-006 SHALL have port mem_data_in, input, 32, store data.
REQ-007 SHALL have port immediate_in, input, 32, U-immediate for LUI.
REQ-008 SHALL have port pc_plus_4_in, input, 32, link value for JAL/JALR.
REQ-009 SHALL have port stall, output, 1, upstream holds its outputs while high.
REQ-010 SHALL have ports dmem_req (out, 1), dmem_we (out, 4, byte enables), dmem_addr (out, 32, word-aligned), dmem_wdata (out, 32), dmem_ready (in, 1, request accepted), dmem_rvalid (in, 1), dmem_rdata (in, 32).
REQ-011 SHALL have ports rd_we (out, 1), rd_addr (out, 5), rd_data (out, 32), the register-file write port.

Function
REQ-012 SHALL latch all inputs into an internal register when in_valid=1 and stall=0; no other capture is allowed.
REQ-013 SHALL decode opcode instruction[6:0]: 0000011 load, 0100011 store, 0110111 LUI, 1101111/1100111 JAL/JALR, 0010011/0110011/0010111 ALU writeback, all others (branch, fence, system) no writeback.
REQ-014 SHALL implement FSM IDLE, MEM_REQ, MEM_WAIT, WB.
REQ-015 IDLE: on capture of a load or store, go to MEM_REQ; on any other capture, go to WB; otherwise stay in IDLE.
REQ-016 MEM_REQ: dmem_req=1 until dmem_ready=1; stores then go to WB with rd_we=0; loads go to MEM_WAIT. If dmem_ready and dmem_rvalid are both high in the same cycle, a load goes directly to WB using that dmem_rdata.
REQ-017 MEM_WAIT: hold until dmem_rvalid=1, register dmem_rdata, go to WB.
REQ-018 WB: drive rd_we/rd_addr/rd_data for exactly one cycle, then go to IDLE, or capture the next instruction in the same cycle.
REQ-019 stall SHALL be 1 in MEM_REQ and MEM_WAIT, and 0 in IDLE and WB.
REQ-020 Non-memory latency: rd_we is high in the cycle following capture. Load latency: 2 cycles minimum (capture, MEM_REQ, WB).
REQ-021 dmem_addr = {alu_result[31:2], 2'b00}.
REQ-022 Store funct3 handling: SB gives dmem_we = 1 << addr[1:0] with the byte replicated x4. SH gives dmem_we = 0011 or 1100 by addr[1] with the half replicated x2. SW gives dmem_we = 1111. Loads give dmem_we = 0000.
REQ-023 Load funct3 handling: LB/LH select the byte or half by addr[1:0] and sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-024 rd_data source: load gives extracted data, LUI gives immediate_in, JAL/JALR gives pc_plus_4_in, ALU class gives alu_result.
REQ-025 rd_we SHALL be forced to 0 when rd_addr=0.
REQ-026 rd_addr = instruction[11:7].

Reset
REQ-027 On rst, and at any time rst is asserted including mid-transaction: state=IDLE, stall=0, dmem_req=0, dmem_we=0, rd_we=0, and all data outputs = 0.
REQ-028 An outstanding memory transaction SHALL be abandoned at reset; a dmem_rvalid arriving in IDLE is ignored.

Configuration
REQ-029 Macro STAGE3_MISALIGN_TRAP_EN: when defined, adds output misaligned (1 bit, reset 0). A misaligned access is SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0.
REQ-030 With STAGE3_MISALIGN_TRAP_EN defined, a misaligned access skips MEM_REQ, issues no dmem_req, enters WB with rd_we=0, and pulses misaligned for one cycle.
REQ-031 Without STAGE3_MISALIGN_TRAP_EN, the misaligned port is absent and the low address bits are used as in REQ-022/023 with no check.

Verification
REQ-032 ADD x5 with alu_result=0x0000_0007 -> next cycle rd_we=1, rd_addr=5, rd_data=0x7, stall=0.
REQ-033 SB at addr 0x1003 with data 0xAB -> dmem_we=1000, dmem_addr=0x1000, dmem_wdata=0xABABABAB; with dmem_ready delayed 3 cycles, stall stays 1 for those cycles and rd_we=0.
REQ-034 LB x1 at addr 0x2002, dmem_rdata=0x0080_0000, rvalid 2 cycles after ready -> rd_data=0xFFFF_FF80; same case with LBU -> rd_data=0x0000_0080.
REQ-035 JAL x0 with pc_plus_4_in=0x104 -> rd_we=0; LUI x3 with immediate_in=0x12345000 -> rd_data=0x12345000.
REQ-036 rst asserted in MEM_WAIT -> outputs return to reset values immediately; a late dmem_rvalid produces no rd_we.
REQ-037 With STAGE3_MISALIGN_TRAP_EN defined, LW at addr 0x3002 -> no dmem_req, misaligned=1 for one cycle, rd_we=0.
